// File: rtl/pong_pkg.sv
// Shared types and geometry for the pong ball path: FSM state, coordinate
// width, default field/paddle dimensions and small arithmetic helpers.
package pong_pkg;

  localparam int COORD_W = 10;
  localparam int CALC_W  = 12;

  localparam int SCREEN_W_DEF      = 640;
  localparam int SCREEN_H_DEF      = 480;
  localparam int BALL_SIZE_DEF     = 8;
  localparam int PADDLE_W_DEF      = 8;
  localparam int PADDLE_H_DEF      = 64;
  localparam int PADDLE_GAP_DEF    = 16;
  localparam int SPEED_DEF         = 2;
  localparam int MAX_SPEED_DEF     = 6;
  localparam int SERVE_STROBES_DEF = 60;

  typedef enum logic [0:0] {
    SERVE = 1'b0,
    PLAY  = 1'b1
  } state_t;

  typedef logic [COORD_W-1:0]       coord_t;
  typedef logic signed [CALC_W-1:0] scalc_t;

  // Coordinates are unsigned; widen with zero bits before signed arithmetic.
  function automatic scalc_t to_calc(input coord_t c);
    return scalc_t'({{(CALC_W-COORD_W){1'b0}}, c});
  endfunction

  function automatic scalc_t with_sign(input logic neg, input scalc_t mag);
    return neg ? -mag : mag;
  endfunction

  function automatic scalc_t sat_inc(input scalc_t v, input scalc_t ceil);
    return (v >= ceil) ? ceil : v + scalc_t'(1);
  endfunction

endpackage

// File: rtl/pong_axis_step.sv
// One-axis ball step: adds the signed velocity, clamps to the low/high
// limits and reflects the velocity away from whichever limit was reached.
module pong_axis_step
  import pong_pkg::*;
(
  input  coord_t pos,
  input  scalc_t vel,
  input  scalc_t lim_lo,
  input  scalc_t lim_hi,
  output scalc_t raw,
  output coord_t next_pos,
  output scalc_t next_vel,
  output logic   hit_low,
  output logic   hit_high
);

  scalc_t mag;

  assign raw = to_calc(pos) + vel;
  assign mag = vel[CALC_W-1] ? -vel : vel;

  // Low limit is tested first so a degenerate field still resolves cleanly.
  always_comb begin
    next_pos = coord_t'(raw);
    next_vel = vel;
    hit_low  = 1'b0;
    hit_high = 1'b0;
    if (raw <= lim_lo) begin
      hit_low  = 1'b1;
      next_pos = coord_t'(lim_lo);
      next_vel = mag;
    end else if (raw >= lim_hi) begin
      hit_high = 1'b1;
      next_pos = coord_t'(lim_hi);
      next_vel = -mag;
    end
  end

endmodule

// File: rtl/pong_ball_ctrl.sv
// Ball motion controller: serve delay, wall and paddle bounces, score pulses.
// Defining PONG_BALL_SPEEDUP_EN adds a saturating speed-up on paddle hits.
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W      = SCREEN_W_DEF,
  parameter int SCREEN_H      = SCREEN_H_DEF,
  parameter int BALL_SIZE     = BALL_SIZE_DEF,
  parameter int PADDLE_W      = PADDLE_W_DEF,
  parameter int PADDLE_H      = PADDLE_H_DEF,
  parameter int PADDLE_GAP    = PADDLE_GAP_DEF,
  parameter int SPEED         = SPEED_DEF,
  parameter int MAX_SPEED     = MAX_SPEED_DEF,
  parameter int SERVE_STROBES = SERVE_STROBES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               strobe_i,
  input  logic [COORD_W-1:0] paddle_l_y_i,
  input  logic [COORD_W-1:0] paddle_r_y_i,
  output logic [COORD_W-1:0] ball_x_o,
  output logic [COORD_W-1:0] ball_y_o,
  output logic               serving_o,
  output logic               score_l_o,
  output logic               score_r_o
);

  localparam coord_t XC     = coord_t'((SCREEN_W - BALL_SIZE) / 2);
  localparam coord_t YC     = coord_t'((SCREEN_H - BALL_SIZE) / 2);
  localparam scalc_t LIM_0  = scalc_t'(0);
  localparam scalc_t X_MAX  = scalc_t'(SCREEN_W - BALL_SIZE);
  localparam scalc_t Y_MAX  = scalc_t'(SCREEN_H - BALL_SIZE);
  localparam scalc_t FACE_L = scalc_t'(PADDLE_GAP + PADDLE_W);
  localparam scalc_t FACE_R = scalc_t'(SCREEN_W - PADDLE_GAP - PADDLE_W - BALL_SIZE);
  localparam int     CNT_W  = (SERVE_STROBES > 1) ? $clog2(SERVE_STROBES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SERVE_STROBES - 1);

  state_t           state;
  coord_t           ball_x;
  coord_t           ball_y;
  logic             dx_neg;
  logic             dy_neg;
  logic [CNT_W-1:0] serve_cnt;

  scalc_t speed;
  scalc_t dx;
  scalc_t dy;
  scalc_t nx;
  scalc_t y_raw;
  coord_t x_step;
  coord_t y_step;
  scalc_t x_vel_nxt;
  scalc_t y_vel_nxt;
  logic   x_lo;
  logic   x_hi;
  logic   y_lo;
  logic   y_hi;
  scalc_t by;
  scalc_t pl;
  scalc_t pr;
  logic   overlap_l;
  logic   overlap_r;
  logic   hit_l;
  logic   hit_r;
  logic   miss_l;
  logic   miss_r;
  logic   play_step;
  coord_t x_nxt;
  logic   dx_neg_nxt;

  assign dx = with_sign(dx_neg, speed);
  assign dy = with_sign(dy_neg, speed);

  pong_axis_step u_step_x (
    .pos      (ball_x),
    .vel      (dx),
    .lim_lo   (LIM_0),
    .lim_hi   (X_MAX),
    .raw      (nx),
    .next_pos (x_step),
    .next_vel (x_vel_nxt),
    .hit_low  (x_lo),
    .hit_high (x_hi)
  );

  pong_axis_step u_step_y (
    .pos      (ball_y),
    .vel      (dy),
    .lim_lo   (LIM_0),
    .lim_hi   (Y_MAX),
    .raw      (y_raw),
    .next_pos (y_step),
    .next_vel (y_vel_nxt),
    .hit_low  (y_lo),
    .hit_high (y_hi)
  );

  // Paddle contact needs the ball to cross the face this step and to share
  // at least one row with the paddle.
  assign by        = to_calc(ball_y);
  assign pl        = to_calc(paddle_l_y_i);
  assign pr        = to_calc(paddle_r_y_i);
  assign overlap_l = (by + scalc_t'(BALL_SIZE) > pl) && (by < pl + scalc_t'(PADDLE_H));
  assign overlap_r = (by + scalc_t'(BALL_SIZE) > pr) && (by < pr + scalc_t'(PADDLE_H));

  assign hit_l  = dx_neg  && (nx <= FACE_L) && (to_calc(ball_x) >= FACE_L) && overlap_l;
  assign hit_r  = !dx_neg && (nx >= FACE_R) && (to_calc(ball_x) <= FACE_R) && overlap_r;
  assign miss_l = dx_neg  && !hit_l && x_lo;
  assign miss_r = !dx_neg && !hit_r && x_hi;

  assign play_step  = strobe_i && (state == PLAY);
  assign x_nxt      = hit_l ? coord_t'(FACE_L) : (hit_r ? coord_t'(FACE_R) : x_step);
  assign dx_neg_nxt = hit_l ? 1'b0 : (hit_r ? 1'b1 : dx_neg);

`ifdef PONG_BALL_SPEEDUP_EN
  scalc_t speed_q;

  // Speed magnitude is shared by both axes and falls back to SPEED on a miss.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      speed_q <= scalc_t'(SPEED);
    end else if (play_step) begin
      if (miss_l || miss_r) begin
        speed_q <= scalc_t'(SPEED);
      end else if (hit_l || hit_r) begin
        speed_q <= sat_inc(speed_q, scalc_t'(MAX_SPEED));
      end
    end
  end

  assign speed = speed_q;
`else
  assign speed = scalc_t'(SPEED);
`endif

  logic unused_bits;
  assign unused_bits = ^{x_vel_nxt, y_raw, y_lo, y_hi, 32'(MAX_SPEED)};

  // A miss re-centres the ball and aims the next serve at the conceding side.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= SERVE;
      serving_o <= 1'b1;
      ball_x    <= XC;
      ball_y    <= YC;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      serve_cnt <= CNT_LOAD;
      score_l_o <= 1'b0;
      score_r_o <= 1'b0;
    end else begin
      score_l_o <= 1'b0;
      score_r_o <= 1'b0;
      if (strobe_i) begin
        case (state)
          SERVE: begin
            if (serve_cnt == '0) begin
              state     <= PLAY;
              serving_o <= 1'b0;
            end else begin
              serve_cnt <= serve_cnt - 1'b1;
            end
          end
          PLAY: begin
            if (miss_l || miss_r) begin
              state     <= SERVE;
              serving_o <= 1'b1;
              serve_cnt <= CNT_LOAD;
              ball_x    <= XC;
              ball_y    <= YC;
              dx_neg    <= miss_l;
              score_r_o <= miss_l;
              score_l_o <= miss_r;
            end else begin
              ball_x <= x_nxt;
              ball_y <= y_step;
              dx_neg <= dx_neg_nxt;
              dy_neg <= y_vel_nxt[CALC_W-1];
            end
          end
          default: begin
            state     <= SERVE;
            serving_o <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ball_x_o = ball_x;
  assign ball_y_o = ball_y;

endmodule
